lsu_exec_unit: RTL

Load/store execution unit directly downstream of the AGU reservation queue. It accepts one issued memory operation at a time: effective address, store data, destination tag, funct3 and load/store flag. It performs the data-memory access over a req/ack handshake and formats the store byte enables or the load extension. For loads it arbitrates for the CDB to publish the result under the destination tag.

---
 rtl/lsu_exec_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_exec_unit.sv
// Load/store execution unit: takes one AGU op at a time, runs the data-memory
// req/ack access, formats store lanes / load extension, publishes loads on CDB.
// Latency: store 2 cycles accept->idle, load result on CDB from cycle 3 (same-cycle ack/grant).
module lsu_exec_unit #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [XLEN-1:0]      ex_address,
  input  logic [XLEN-1:0]      ex_data,
  input  logic [TAG_WIDTH-1:0] rd_tag,
  input  logic                 rd_tag_valid,
  input  logic [2:0]           funct3,
  input  logic                 agu_ls,
  output logic                 ex_done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [3:0]           mem_be,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 mem_ack,
  output logic                 cdb_req,
  input  logic                 cdb_grant,
  output logic                 cdb_valid,
  output logic [TAG_WIDTH-1:0] cdb_tag,
  output logic [XLEN-1:0]      cdb_data,
  output logic                 ls_fault
);

  typedef enum logic [1:0] {IDLE, MEM, CDB} state_t;

  state_t               state_q, state_d;
  logic [XLEN-1:0]      addr_q, addr_d;
  logic [XLEN-1:0]      data_q, data_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 tagv_q, tagv_d;
  logic [2:0]           f3_q, f3_d;
  logic                 ls_q, ls_d;
  logic                 fault_q, fault_d;
  logic [XLEN-1:0]      cdb_data_q, cdb_data_d;

  logic                 acc_fault;
  logic [XLEN-1:0]      st_wdata;
  logic [3:0]           st_be;
  logic [XLEN-1:0]      ld_shift;
  logic [XLEN-1:0]      ld_val;

  // Decode misalignment / illegal width of the op currently offered at the queue head.
  always_comb begin
    acc_fault = 1'b0;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) acc_fault = 1'b1;
    if (agu_ls && funct3[2]) acc_fault = 1'b1;
    if (funct3[1:0] == 2'b01 && ex_address[0]) acc_fault = 1'b1;
    if (funct3 == 3'b010 && ex_address[1:0] != 2'b00) acc_fault = 1'b1;
  end

  // Store lane replication and byte enables from the latched op; loads read the whole word.
  always_comb begin
    st_wdata = data_q;
    st_be    = 4'b1111;
    if (ls_q) begin
      case (f3_q[1:0])
        2'b00: begin
          st_wdata = {4{data_q[7:0]}};
          st_be    = 4'b0001 << addr_q[1:0];
        end
        2'b01: begin
          st_wdata = {2{data_q[15:0]}};
          st_be    = 4'b0011 << addr_q[1:0];
        end
        default: begin
          st_wdata = data_q;
          st_be    = 4'b1111;
        end
      endcase
    end
  end

  // Shift the addressed byte/half down to bit 0 and extend per funct3.
  always_comb begin
    ld_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    ld_val   = '0;
    case (f3_q)
      3'b000:  ld_val = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      3'b001:  ld_val = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      3'b010:  ld_val = mem_rdata;
      default: ld_val = '0;
    endcase
  end

  // State and latched-op registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      tagv_q     <= 1'b0;
      f3_q       <= 3'b000;
      ls_q       <= 1'b0;
      fault_q    <= 1'b0;
      cdb_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      tagv_q     <= tagv_d;
      f3_q       <= f3_d;
      ls_q       <= ls_d;
      fault_q    <= fault_d;
      cdb_data_q <= cdb_data_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tag_d      = tag_q;
    tagv_d     = tagv_q;
    f3_d       = f3_q;
    ls_d       = ls_q;
    fault_d    = 1'b0;
    cdb_data_d = cdb_data_q;
    ex_done    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = 4'b0000;
    cdb_req    = 1'b0;
    cdb_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        // Reset gates the accept pulse so the queue never dequeues into a discarded op.
        ex_done = issue_valid & ~rst;
        if (issue_valid) begin
          addr_d  = ex_address;
          data_d  = ex_data;
          tag_d   = rd_tag;
          tagv_d  = rd_tag_valid;
          f3_d    = funct3;
          ls_d    = agu_ls;
          fault_d = acc_fault;
          if (!acc_fault) begin
            state_d = MEM;
          end else if (!agu_ls && rd_tag_valid) begin
            // Faulting load still retires its tag so dependents are not left waiting.
            cdb_data_d = '0;
            state_d    = CDB;
          end
        end
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = ls_q;
        mem_addr  = {addr_q[XLEN-1:2], 2'b00};
        mem_wdata = st_wdata;
        mem_be    = st_be;
        if (mem_ack) begin
          if (!ls_q && tagv_q) begin
            cdb_data_d = ld_val;
            state_d    = CDB;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CDB: begin
        cdb_req   = 1'b1;
        cdb_valid = cdb_grant;
        if (cdb_grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cdb_tag  = tag_q;
  assign cdb_data = cdb_data_q;
  assign ls_fault = fault_q;

endmodule
